fwd_scoreboard: RTL and testbench

- Parametrised operand-forwarding and load-use scoreboard for the pipelined CPU datapath.
- Tracks destination-register metadata of in-flight instructions across DEPTH post-EX stages in an internal shift register.
- Resolves each of NUM_SRC EX-stage source operands to the youngest producing stage or the register file.
- Raises a stall when the youngest producer is a load whose data is not yet available.
- Replaces the fixed two-stage, two-operand forwarding glue; supports deeper pipelines (split MEM, multi-cycle WB).

---
 rtl/fwd_scoreboard_if.sv | 38 +++
 rtl/fwd_scoreboard.sv | 126 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Bundle between the pipeline control and the forwarding scoreboard.
// master: pipeline/datapath side; slave: the scoreboard itself.
interface fwd_scoreboard_if #(
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned WORD_W  = 32
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                        adv;
  logic                        flush_all;
  logic                        iss_valid;
  logic                        iss_RegWr;
  logic                        iss_DataRead;
  logic [REG_W-1:0]            iss_wsel;
  logic [DEPTH*WORD_W-1:0]     stg_wdat;
  logic [NUM_SRC*REG_W-1:0]    src_sel;
  logic [NUM_SRC*WORD_W-1:0]   src_rdat;
  logic [NUM_SRC*WORD_W-1:0]   src_data;
  logic [NUM_SRC-1:0]          src_fwd;
  logic                        stall;
  logic [CNT_W-1:0]            inflight;

  modport master (
    output adv, flush_all, iss_valid, iss_RegWr, iss_DataRead, iss_wsel,
    output stg_wdat, src_sel, src_rdat,
    input  src_data, src_fwd, stall, inflight
  );

  modport slave (
    input  adv, flush_all, iss_valid, iss_RegWr, iss_DataRead, iss_wsel,
    input  stg_wdat, src_sel, src_rdat,
    output src_data, src_fwd, stall, inflight
  );

endinterface

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use scoreboard. Keeps destination metadata for
// DEPTH post-EX stages in a shift register and resolves each EX source operand
// to the youngest producing stage, or to the register file when none matches.
module fwd_scoreboard #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic               CLK,
  input  logic               nRST,
  fwd_scoreboard_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 1) begin : g_bad_depth
    $error("fwd_scoreboard: DEPTH must be at least 1");
  end
  if (NUM_SRC < 1) begin : g_bad_nsrc
    $error("fwd_scoreboard: NUM_SRC must be at least 1");
  end
  if (LOAD_STAGE >= DEPTH) begin : g_bad_ldstg
    $error("fwd_scoreboard: LOAD_STAGE must be below DEPTH");
  end

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic             ld;
    logic [REG_W-1:0] wsel;
  } entry_t;

  entry_t entry_q [DEPTH];
  entry_t entry_d [DEPTH];

  logic [NUM_SRC*WORD_W-1:0] src_data_c;
  logic [NUM_SRC-1:0]        src_fwd_c;
  logic [NUM_SRC-1:0]        hazard_c;
  logic [CNT_W-1:0]          inflight_c;

  // Next-state: flush beats advance; advance shifts toward the oldest stage.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (bus.flush_all) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_d[i] = '0;
      end
    end else if (bus.adv) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        entry_d[i] = entry_q[i-1];
      end
      if (bus.iss_valid) begin
        entry_d[0].valid = 1'b1;
        entry_d[0].wr    = bus.iss_RegWr;
        entry_d[0].ld    = bus.iss_DataRead;
        entry_d[0].wsel  = bus.iss_wsel;
      end else begin
        entry_d[0] = '0;
      end
    end
  end

  // Stage metadata register, cleared asynchronously.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Operand resolution: the youngest match decides, even if it is an unready load.
  always_comb begin
    logic [REG_W-1:0] sel;
    logic             found;
    src_data_c = '0;
    src_fwd_c  = '0;
    hazard_c   = '0;
    sel        = '0;
    found      = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      sel   = bus.src_sel[k*REG_W +: REG_W];
      found = 1'b0;
      src_data_c[k*WORD_W +: WORD_W] = bus.src_rdat[k*WORD_W +: WORD_W];
      if (sel == '0) begin
        // r0 reads as zero regardless of the register file or any producer.
        src_data_c[k*WORD_W +: WORD_W] = '0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (!found && entry_q[i].valid && entry_q[i].wr && (entry_q[i].wsel == sel)) begin
            found = 1'b1;
            if (!entry_q[i].ld || (i >= LOAD_STAGE)) begin
              src_data_c[k*WORD_W +: WORD_W] = bus.stg_wdat[i*WORD_W +: WORD_W];
              src_fwd_c[k] = 1'b1;
            end else begin
              hazard_c[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Count of entries that will eventually write the register file.
  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      inflight_c = inflight_c + CNT_W'(entry_q[i].valid & entry_q[i].wr);
    end
  end

  assign bus.src_data = src_data_c;
  assign bus.src_fwd  = src_fwd_c;
  assign bus.stall    = |hazard_c;
  assign bus.inflight = inflight_c;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios followed by a
// randomized phase, all checked against an age-based instruction-list model.
module tb_fwd_scoreboard;

  localparam int unsigned DEPTH      = 3;
  localparam int unsigned NUM_SRC    = 2;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LOAD_STAGE = 1;

  logic CLK;
  logic nRST;

  fwd_scoreboard_if #(
    .DEPTH   (DEPTH),
    .NUM_SRC (NUM_SRC),
    .REG_W   (REG_W),
    .WORD_W  (WORD_W)
  ) bus ();

  fwd_scoreboard #(
    .DEPTH      (DEPTH),
    .NUM_SRC    (NUM_SRC),
    .REG_W      (REG_W),
    .WORD_W     (WORD_W),
    .LOAD_STAGE (LOAD_STAGE)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Each in-flight instruction carries its age (stages since leaving EX).
  typedef struct {
    bit               wr;
    bit               ld;
    logic [REG_W-1:0] wsel;
    int               age;
  } rec_t;
  rec_t recs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: pick the youngest producing instruction for operand k.
  function automatic void model_resolve(input int k, output logic [31:0] d, output logic f,
                                        output logic h);
    logic [REG_W-1:0] sel;
    int best;
    int best_age;
    sel = bus.src_sel[k*REG_W +: REG_W];
    d = bus.src_rdat[k*WORD_W +: WORD_W];
    f = 1'b0;
    h = 1'b0;
    best = -1;
    best_age = DEPTH;
    if (sel == 0) begin
      d = 32'h0;
      return;
    end
    foreach (recs[j]) begin
      if (recs[j].wr && recs[j].wsel == sel && recs[j].age < best_age) begin
        best = j;
        best_age = recs[j].age;
      end
    end
    if (best >= 0) begin
      if (!recs[best].ld || best_age >= int'(LOAD_STAGE)) begin
        d = bus.stg_wdat[best_age*WORD_W +: WORD_W];
        f = 1'b1;
      end else begin
        h = 1'b1;
      end
    end
  endfunction

  function automatic logic model_stall();
    logic [31:0] d;
    logic f, h, s;
    s = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      model_resolve(k, d, f, h);
      s |= h;
    end
    return s;
  endfunction

  function automatic int model_inflight();
    int n = 0;
    foreach (recs[j]) if (recs[j].wr) n++;
    return n;
  endfunction

  function automatic void model_clock(input bit a, input bit fl, input bit iv, input bit w,
                                      input bit l, input logic [REG_W-1:0] ws);
    rec_t r;
    if (fl) begin
      recs.delete();
    end else if (a) begin
      foreach (recs[j]) recs[j].age++;
      while (recs.size() > 0 && recs[recs.size()-1].age >= int'(DEPTH)) void'(recs.pop_back());
      if (iv) begin
        r.wr = w; r.ld = l; r.wsel = ws; r.age = 0;
        recs.push_front(r);
      end
    end
  endfunction

  // Drive control for one edge, then advance the model alongside the DUT.
  task automatic step(input bit a, input bit fl, input bit iv, input bit w, input bit l,
                      input logic [REG_W-1:0] ws);
    bus.adv = a; bus.flush_all = fl; bus.iss_valid = iv;
    bus.iss_RegWr = w; bus.iss_DataRead = l; bus.iss_wsel = ws;
    @(posedge CLK);
    model_clock(a, fl, iv, w, l, ws);
    #1;
    bus.adv = 1'b0; bus.flush_all = 1'b0; bus.iss_valid = 1'b0;
    bus.iss_RegWr = 1'b0; bus.iss_DataRead = 1'b0; bus.iss_wsel = '0;
  endtask

  task automatic set_ops(input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1,
                         input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    bus.src_sel  = {s1, s0};
    bus.src_rdat = {r1, r0};
    bus.stg_wdat = {w2, w1, w0};
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d;
    logic f, h, s;
    s = 1'b0;
    #1;
    for (int k = 0; k < NUM_SRC; k++) begin
      model_resolve(k, d, f, h);
      s |= h;
      chk($sformatf("%s_data%0d", tag, k), bus.src_data[k*WORD_W +: WORD_W], d);
      chk($sformatf("%s_fwd%0d", tag, k), 32'(bus.src_fwd[k]), 32'(f));
    end
    chk({tag, "_stall"}, 32'(bus.stall), 32'(s));
    chk({tag, "_inflight"}, 32'(bus.inflight), 32'(model_inflight()));
  endtask

  initial begin
    nRST = 1'b1;
    bus.adv = 1'b0; bus.flush_all = 1'b0; bus.iss_valid = 1'b0;
    bus.iss_RegWr = 1'b0; bus.iss_DataRead = 1'b0; bus.iss_wsel = '0;
    set_ops(5'd3, 5'd0, 32'hAAAA_0001, 32'hBBBB_0002, 32'h1, 32'h2, 32'h3);
    repeat (2) @(posedge CLK);
    #2;
    check_all("reset");
    chk("reset_rdat", bus.src_data[31:0], 32'hAAAA_0001);
    chk("reset_r0", bus.src_data[63:32], 32'h0);
    nRST = 1'b0;

    // Youngest producer wins over an older one of the same register.
    step(1, 0, 1, 1, 0, 5'd5);
    step(1, 0, 1, 1, 0, 5'd5);
    set_ops(5'd5, 5'd1, 32'h5555, 32'h1111, 32'h22, 32'h11, 32'h0);
    check_all("young");
    chk("young_val", bus.src_data[31:0], 32'h22);
    chk("young_fwd", 32'(bus.src_fwd[0]), 32'd1);

    // Asynchronous reset with three live entries.
    step(1, 0, 1, 1, 0, 5'd6);
    chk("pre_reset_inflight", 32'(bus.inflight), 32'd3);
    nRST = 1'b1;
    #1;
    recs.delete();
    check_all("midreset");
    chk("midreset_inflight", 32'(bus.inflight), 32'd0);
    @(posedge CLK);
    #2;
    nRST = 1'b0;

    // Load-use: unready in stage 0, forwarded once it reaches stage 1.
    step(1, 0, 1, 1, 1, 5'd7);
    set_ops(5'd0, 5'd7, 32'h0, 32'h7777, 32'h70, 32'h71, 32'h72);
    check_all("lduse0");
    chk("lduse0_stall", 32'(bus.stall), 32'd1);
    step(1, 0, 0, 0, 0, 5'd0);
    check_all("lduse1");
    chk("lduse1_stall", 32'(bus.stall), 32'd0);
    chk("lduse1_val", bus.src_data[63:32], 32'h71);

    // r0 is never forwarded but still counts as in flight.
    step(0, 1, 0, 0, 0, 5'd0);
    step(1, 0, 1, 1, 0, 5'd0);
    set_ops(5'd0, 5'd0, 32'h1234, 32'h5678, 32'hDEAD, 32'h0, 32'h0);
    check_all("reg0");
    chk("reg0_inflight", 32'(bus.inflight), 32'd1);

    // Hold for four cycles, then flush together with advance.
    step(1, 0, 1, 1, 0, 5'd4);
    set_ops(5'd4, 5'd0, 32'h44, 32'h0, 32'h40, 32'h41, 32'h42);
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 0, 0, 5'd0);
      check_all($sformatf("hold%0d", c));
    end
    step(1, 1, 1, 1, 0, 5'd4);
    check_all("flush");
    chk("flush_inflight", 32'(bus.inflight), 32'd0);

    // Aging through all stages.
    step(1, 0, 1, 1, 0, 5'd9);
    set_ops(5'd9, 5'd9, 32'h90, 32'h91, 32'hA0, 32'hA1, 32'hA2);
    check_all("age0");
    for (int c = 1; c <= 3; c++) begin
      step(1, 0, 0, 0, 0, 5'd0);
      check_all($sformatf("age%0d", c));
    end
    chk("aged_out_fwd", 32'(bus.src_fwd), 32'd0);

    // Randomized traffic; bubble inserted whenever a stall coincides with advance.
    for (int n = 0; n < 400; n++) begin
      bit a, fl, iv;
      a  = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 19) == 0);
      iv = $urandom_range(0, 1) == 1;
      if (model_stall() && a) iv = 1'b0;
      step(a, fl, iv, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           REG_W'($urandom_range(0, 7)));
      set_ops(REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, $urandom, $urandom);
      check_all($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
